// File: rtl/queue_cmd_frontend_if.sv
// queue_cmd_frontend_if
//   Bundles the upstream push/pop/read-response handshakes and the
//   downstream RAM-queue command port of queue_cmd_frontend.
//   slave  : the front end itself (drives ready, rd_*, q_*, count, err_sticky)
//   master : the surrounding logic (upstream requester plus the queue)
interface queue_cmd_frontend_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
);
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_ready;
  logic                  pop_valid;
  logic                  pop_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  q_active;
  logic                  q_cmd;
  logic [DATA_WIDTH-1:0] q_data;
  logic [DATA_WIDTH-1:0] q_data_out;
  logic                  q_underflow;
  logic                  q_overflow;
  logic [ADDR_WIDTH:0]   count;
  logic                  err_sticky;
  logic                  err_clear;

  modport slave (
    input  push_valid, push_data, pop_valid, q_data_out, q_underflow, q_overflow, err_clear,
    output push_ready, pop_ready, rd_valid, rd_data, q_active, q_cmd, q_data, count, err_sticky
  );

  modport master (
    output push_valid, push_data, pop_valid, q_data_out, q_underflow, q_overflow, err_clear,
    input  push_ready, pop_ready, rd_valid, rd_data, q_active, q_cmd, q_data, count, err_sticky
  );
endinterface

// File: rtl/queue_cmd_frontend.sv
// queue_cmd_frontend
//   Turns independent push/pop valid/ready streams into single-cycle
//   active/cmd pulses for the RAM queue, spaced GAP cycles apart. A shadow
//   occupancy count prevents overflowing pushes and underflowing pops.
//   Popped words are sampled from the queue and returned on rd_valid/rd_data.
//   Queue under/overflow flags are latched into err_sticky.
// Ports
//   clk, rst_n : clock, async active-low reset
//   bus        : queue_cmd_frontend_if.slave (push/pop/rd handshakes, queue
//                command port, count, err_sticky/err_clear)
//
// state | meaning
// IDLE  | accepting one push or pop handshake
// ISSUE | q_active pulse, count updated
// WAIT  | queue settle time, pop data sampled on the last cycle
module queue_cmd_frontend #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4,
  parameter int GAP        = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  queue_cmd_frontend_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int GW    = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);
  localparam logic [GW-1:0]       GAP_C   = GW'(GAP);
  localparam logic [GW-1:0]       GONE_C  = GW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]            state;
  logic                  op_push;
  logic                  last_push;
  logic                  ready_en;
  logic                  rd_valid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] q_data_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [GW-1:0]         gap_cnt;

  logic idle;
  logic push_legal;
  logic pop_legal;
  logic push_rdy;
  logic pop_rdy;
  logic push_hs;
  logic pop_hs;

  // ready_en keeps both readies low while in reset and for the release cycle
  assign idle       = (state == S_IDLE) & ready_en;
  assign push_legal = (count_q < DEPTH_C);
  assign pop_legal  = (count_q != '0);

  // Each side loses only when the other side is requesting, is legal, and
  // holds the round-robin turn; illegal sides never block the other.
  assign push_rdy = idle & push_legal & ~(bus.pop_valid & pop_legal & last_push);
  assign pop_rdy  = idle & pop_legal & ~(bus.push_valid & push_legal & ~last_push);
  assign push_hs  = bus.push_valid & push_rdy;
  assign pop_hs   = bus.pop_valid & pop_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_push    <= 1'b0;
      last_push  <= 1'b0;
      ready_en   <= 1'b0;
      rd_valid_q <= 1'b0;
      q_data_q   <= '0;
      rd_data_q  <= '0;
      count_q    <= '0;
      gap_cnt    <= '0;
    end else begin
      ready_en   <= 1'b1;
      rd_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (push_hs) begin
            op_push   <= 1'b1;
            last_push <= 1'b1;
            q_data_q  <= bus.push_data;
            state     <= S_ISSUE;
          end else if (pop_hs) begin
            op_push   <= 1'b0;
            last_push <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          count_q <= op_push ? (count_q + ONE_C) : (count_q - ONE_C);
          gap_cnt <= GAP_C;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          gap_cnt <= gap_cnt - GONE_C;
          if (gap_cnt == GONE_C) begin
            if (!op_push) begin
              rd_data_q  <= bus.q_data_out;
              rd_valid_q <= 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // set has priority over clear so an error in the clear cycle is not lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bus.q_underflow | bus.q_overflow) begin
      err_q <= 1'b1;
    end else if (bus.err_clear) begin
      err_q <= 1'b0;
    end
  end

  assign bus.push_ready = push_rdy;
  assign bus.pop_ready  = pop_rdy;
  assign bus.q_active   = (state == S_ISSUE);
  assign bus.q_cmd      = (state == S_ISSUE) & op_push;
  assign bus.q_data     = q_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.count      = count_q;
  assign bus.err_sticky = err_q;

endmodule

// File: doc/queue_cmd_frontend.md
# queue_cmd_frontend

Upstream command front end for the RAM queue. It converts two independent valid/ready request streams (push, pop) into the queue's single-pulse `active`/`cmd` command interface, and keeps a shadow occupancy count so it never issues an overflowing push or an underflowing pop. It also captures pop data from the queue's `data_out` and returns it on a read-response strobe. It latches any queue under/overflow flag as a sticky error.

## Interface
- `DATA_WIDTH`, 6, payload width; must match the queue.
- `ADDR_WIDTH`, 4, queue address width; queue depth = 2**ADDR_WIDTH.
- `GAP`, 3, settle cycles after each command before the queue accepts another (≥1).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `push_valid` in 1: push request.
- `push_data` in DATA_WIDTH: push payload.
- `push_ready` out 1: push accepted when `push_valid & push_ready`.
- `pop_valid` in 1: pop request.
- `pop_ready` out 1: pop accepted when `pop_valid & pop_ready`.
- `rd_valid` out 1: one-cycle strobe; popped word is on `rd_data`.
- `rd_data` out DATA_WIDTH: popped word; holds until the next `rd_valid`.
- `q_active` out 1: to queue `active`.
- `q_cmd` out 1: to queue `cmd`; 1 = push, 0 = pop.
- `q_data` out DATA_WIDTH: to queue `data_in`.
- `q_data_out` in DATA_WIDTH: from queue `data_out`.
- `q_underflow` in 1: from queue `signal_underflow`.
- `q_overflow` in 1: from queue `signal_overflow`.
- `count` out ADDR_WIDTH+1: shadow occupancy, 0..2**ADDR_WIDTH.
- `err_sticky` out 1: latched queue under/overflow.
- `err_clear` in 1: synchronous clear of `err_sticky`.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - `push_ready` = (count < DEPTH) & grant_push.
  - `pop_ready` = (count > 0) & grant_pop.
  - On a handshake, register the opcode and `push_data`, then go to ISSUE.
- **Arbitration** (both valid and both legal)
  - Pop wins if count == DEPTH.
  - Push wins if count == 0.
  - Otherwise round-robin: whichever was not served last wins. The last-served flag resets to "pop", so push wins first.
  - Exactly one of `push_ready`/`pop_ready` is high per cycle.
- **ISSUE** (exactly one cycle)
  - `q_active` = 1, `q_cmd` = opcode, `q_data` = latched payload.
  - count ±1 at end of cycle; a push at DEPTH or a pop at 0 cannot occur.
  - Load the gap counter with GAP, then go to WAIT.
- **WAIT**
  - `q_active` = 0; the gap counter decrements each cycle.
  - On the last WAIT cycle (counter == 1) of a pop, sample `q_data_out` into `rd_data`.
  - Then go to IDLE.
- **rd_valid**: high for exactly the one cycle after the pop sample, i.e. the first IDLE cycle.
- **Error flag**
  - `err_sticky` sets on any cycle with `q_underflow | q_overflow`.
  - `err_clear` clears it; set wins over clear in the same cycle.
  - The error flag does not block traffic.
- `q_data` holds its last value outside ISSUE; `q_cmd` = 0 outside ISSUE.

## Timing
- Reset values (all outputs): `push_ready`, `pop_ready`, `rd_valid`, `q_active`, `q_cmd`, `err_sticky` = 0; `count`, `rd_data`, `q_data` = 0; state = IDLE.
- Ready signals are valid from the first cycle after reset release.
- Cycle timeline for a handshake in cycle T:
  - T+1: `q_active` = 1.
  - T+2 .. T+1+GAP: WAIT.
  - Pop: `q_data_out` is sampled at the end of T+1+GAP; `rd_valid` is high in T+2+GAP.
  - Next handshake possible in T+2+GAP.
  - Maximum throughput: one op per GAP+2 cycles.
- `count` reflects the operation from T+2 onward.
- Ready outputs are combinational from state, count, arbitration flag and the opposite valid. They do not depend on their own valid.
- Reset mid-operation: an in-flight command is dropped and all registers return to reset values. The queue shares `rst_n`, so the count of 0 stays consistent.
- count is ADDR_WIDTH+1 bits wide; it never wraps.

## Test plan
- Push 0x15 with count 0 → `q_active`/`q_cmd` = 1 and `q_data` = 0x15 at T+1; `count` = 1 at T+2; `pop_ready` = 0 while count was 0.
- Push 16 words (DEPTH=16) → `count` = 16 and `push_ready` stays 0 with `push_valid` held. Then a pop returns the first word, with `rd_valid` at T+5 (GAP=3).
- Hold push and pop valid with count = 5 → grants alternate push, pop, push…; count oscillates 6, 5, 6. At count 16 pop is granted; at count 0 push is granted.
- Pop with count 0 → no handshake, `q_active` never asserts, `count` stays 0, `err_sticky` = 0.
- Force `q_overflow` = 1 for one cycle → `err_sticky` = 1 next cycle. With `err_clear` and `q_underflow` asserted in the same cycle it stays 1; `err_clear` alone → 0.
- Assert `rst_n` = 0 in a WAIT cycle → all outputs go to reset values immediately. `rd_valid` does not pulse after release and `count` = 0.
